// File: rtl/conv_result_collector_if.sv
// Pixel stream in from the conv core and drain stream out to the consumer.
interface conv_result_collector_if #(
   parameter int unsigned D_W = 21
);
   logic           i_valid;
   logic [D_W-1:0] i_data;
   logic           o_rd_valid;
   logic [D_W-1:0] o_rd_data;
   logic           o_rd_last;
   logic           i_rd_ready;

   modport master (
      output i_valid, i_data, i_rd_ready,
      input  o_rd_valid, o_rd_data, o_rd_last
   );

   modport slave (
      input  i_valid, i_data, i_rd_ready,
      output o_rd_valid, o_rd_data, o_rd_last
   );
endinterface

// File: rtl/conv_result_collector.sv
// Buffers one 28x28 conv output frame in raster order, then drains it over valid/ready.
module conv_result_collector #(
   parameter int unsigned D_W     = 21,
   parameter int unsigned OUT_DIM = 28
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   conv_result_collector_if.slave  bus,
   output logic [4:0]              o_row,
   output logic [4:0]              o_col,
   output logic                    o_busy,
   output logic                    o_frame_done,
   output logic                    o_overflow
);
   localparam int unsigned FRAME     = OUT_DIM * OUT_DIM;
   localparam logic [9:0]  LAST_ADDR = 10'(FRAME - 1);
   localparam logic [4:0]  LAST_COL  = 5'(OUT_DIM - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t         state;
   logic [9:0]     wr_addr;
   logic [9:0]     rd_addr;
   logic [4:0]     row;
   logic [4:0]     col;
   logic           rd_valid;
   logic [D_W-1:0] mem [FRAME];

   // No reset on the buffer: contents are meaningless until a frame is written.
   always_ff @(posedge i_clk) begin
      if (bus.i_valid && state != DRAIN)
         mem[wr_addr] <= bus.i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         wr_addr      <= '0;
         rd_addr      <= '0;
         row          <= '0;
         col          <= '0;
         rd_valid     <= 1'b0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         case (state)
            IDLE, COLLECT: begin
               if (bus.i_valid) begin
                  if (wr_addr == LAST_ADDR) begin
                     state        <= DRAIN;
                     wr_addr      <= '0;
                     row          <= '0;
                     col          <= '0;
                     rd_valid     <= 1'b1;
                     o_frame_done <= 1'b1;
                  end else begin
                     state   <= COLLECT;
                     wr_addr <= wr_addr + 10'd1;
                     if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 5'd1;
                     end else begin
                        col <= col + 5'd1;
                     end
                  end
                  o_busy <= 1'b1;
               end
            end
            DRAIN: begin
               if (bus.i_valid)
                  o_overflow <= 1'b1;
               if (bus.i_rd_ready) begin
                  if (rd_addr == LAST_ADDR) begin
                     state    <= IDLE;
                     rd_addr  <= '0;
                     rd_valid <= 1'b0;
                     o_busy   <= 1'b0;
                  end else begin
                     rd_addr <= rd_addr + 10'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_rd_valid = rd_valid;
   assign bus.o_rd_data  = mem[rd_addr];
   assign bus.o_rd_last  = rd_valid && (rd_addr == LAST_ADDR);
   assign o_row          = row;
   assign o_col          = col;
endmodule
